// File: rtl/clap_sequence_decoder.sv
// Clap-pattern decoder: matches SEQ_LEN groups of exactly GROUP_CLAPS claps, separated by
// at most GAP_MAX silent windows, and toggles the light through a valid/ready token.
module clap_sequence_decoder #(
    parameter int SUC_CLAPS_WIDTH = 16,
    parameter int SEQ_LEN         = 2,
    parameter int GROUP_CLAPS     = 2,
    parameter int GAP_MAX         = 4,
    localparam int GRP_W          = $clog2(SEQ_LEN + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [SUC_CLAPS_WIDTH-1:0] suc_claps_data,
    input  logic                       suc_claps_valid,
    output logic                       suc_claps_ready,
    output logic                       toggle_data,
    output logic                       toggle_valid,
    input  logic                       toggle_ready,
    output logic                       light_on,
    output logic                       mismatch,
    output logic [GRP_W-1:0]           match_progress
);

    localparam int GAP_W = $clog2(GAP_MAX + 1);
    localparam logic [SUC_CLAPS_WIDTH-1:0] GROUP_C = SUC_CLAPS_WIDTH'(GROUP_CLAPS);
    localparam logic [SUC_CLAPS_WIDTH-1:0] ZERO_C  = SUC_CLAPS_WIDTH'(0);
    localparam logic [GRP_W-1:0]           SEQ_C   = GRP_W'(SEQ_LEN);
    localparam logic [GAP_W-1:0]           GAP_C   = GAP_W'(GAP_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MATCH = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [GRP_W-1:0]   group_cnt_r, group_cnt_s;
    logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_s;
    logic               ready_s, light_s, tdata_s, tvalid_s, mismatch_s;
    logic               enter_issue_s;
    logic               accept_s;

    assign accept_s       = suc_claps_valid & suc_claps_ready;
    assign match_progress = group_cnt_r;

    // Next-state, counter and output computation.
    always_comb begin
        state_s       = state_r;
        group_cnt_s   = group_cnt_r;
        gap_cnt_s     = gap_cnt_r;
        light_s       = light_on;
        tdata_s       = toggle_data;
        tvalid_s      = toggle_valid;
        mismatch_s    = 1'b0;
        enter_issue_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (suc_claps_data == GROUP_C)) begin
                    group_cnt_s = GRP_W'(1);
                    gap_cnt_s   = GAP_W'(0);
                    if (SEQ_LEN == 1) begin
                        state_s       = ST_ISSUE;
                        enter_issue_s = 1'b1;
                    end else begin
                        state_s = ST_MATCH;
                    end
                end else if (accept_s && (suc_claps_data != ZERO_C)) begin
                    mismatch_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MATCH: begin
                if (!accept_s) begin
                    state_s = ST_MATCH;
                end else if (suc_claps_data == ZERO_C) begin
                    // Silence beyond the allowed gap quietly abandons the attempt.
                    if (gap_cnt_r == GAP_C) begin
                        state_s     = ST_IDLE;
                        group_cnt_s = GRP_W'(0);
                        gap_cnt_s   = GAP_W'(0);
                    end else begin
                        gap_cnt_s = gap_cnt_r + GAP_W'(1);
                    end
                end else if (suc_claps_data == GROUP_C) begin
                    group_cnt_s = group_cnt_r + GRP_W'(1);
                    gap_cnt_s   = GAP_W'(0);
                    if ((group_cnt_r + GRP_W'(1)) == SEQ_C) begin
                        state_s       = ST_ISSUE;
                        enter_issue_s = 1'b1;
                    end else begin
                        state_s = ST_MATCH;
                    end
                end else begin
                    state_s     = ST_IDLE;
                    group_cnt_s = GRP_W'(0);
                    gap_cnt_s   = GAP_W'(0);
                    mismatch_s  = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (toggle_ready) begin
                    tvalid_s    = 1'b0;
                    state_s     = ST_IDLE;
                    group_cnt_s = GRP_W'(0);
                    gap_cnt_s   = GAP_W'(0);
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                group_cnt_s = GRP_W'(0);
                gap_cnt_s   = GAP_W'(0);
                tvalid_s    = 1'b0;
            end
        endcase
        if (enter_issue_s) begin
            light_s  = ~light_on;
            tdata_s  = ~light_on;
            tvalid_s = 1'b1;
        end else begin
            light_s = light_s;
        end
        ready_s = (state_s != ST_ISSUE);
    end

    // State, counter and registered-output flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            group_cnt_r     <= GRP_W'(0);
            gap_cnt_r       <= GAP_W'(0);
            suc_claps_ready <= 1'b0;
            light_on        <= 1'b0;
            toggle_data     <= 1'b0;
            toggle_valid    <= 1'b0;
            mismatch        <= 1'b0;
        end else begin
            state_r         <= state_s;
            group_cnt_r     <= group_cnt_s;
            gap_cnt_r       <= gap_cnt_s;
            suc_claps_ready <= ready_s;
            light_on        <= light_s;
            toggle_data     <= tdata_s;
            toggle_valid    <= tvalid_s;
            mismatch        <= mismatch_s;
        end
    end

endmodule

// File: tb/tb_clap_sequence_decoder.sv
// Bench for clap_sequence_decoder: vector table, hand-written corner sequences and random
// traffic checked against a group-counting reference model.
module tb_clap_sequence_decoder;

    localparam int W       = 16;
    localparam int SEQ_LEN = 2;
    localparam int GC      = 2;
    localparam int GAP_MAX = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] suc_claps_data;
    logic         suc_claps_valid;
    logic         suc_claps_ready;
    logic         toggle_data;
    logic         toggle_valid;
    logic         toggle_ready;
    logic         light_on;
    logic         mismatch;
    logic [1:0]   match_progress;

    clap_sequence_decoder #(
        .SUC_CLAPS_WIDTH(W), .SEQ_LEN(SEQ_LEN), .GROUP_CLAPS(GC), .GAP_MAX(GAP_MAX)
    ) dut (
        .clock(clock), .reset(reset),
        .suc_claps_data(suc_claps_data), .suc_claps_valid(suc_claps_valid),
        .suc_claps_ready(suc_claps_ready),
        .toggle_data(toggle_data), .toggle_valid(toggle_valid), .toggle_ready(toggle_ready),
        .light_on(light_on), .mismatch(mismatch), .match_progress(match_progress)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int tok_cnt = 0;
    int acc_cnt = 0;

    // Reference model: groups matched so far, silent windows since last group, token state.
    int m_groups, m_gaps;
    bit m_light, m_td, m_tv, m_mis, m_ready;

    typedef struct {
        logic [W-1:0] c;
        logic         v;
        logic         tr;
        logic [1:0]   prog;
        logic         tv;
        logic         light;
        logic         mis;
    } vec_t;
    vec_t vecs[$];

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_groups = 0; m_gaps = 0; m_light = 0; m_td = 0; m_tv = 0; m_mis = 0; m_ready = 0;
    endtask

    task automatic check_model();
        cmp("ready",    32'(suc_claps_ready), 32'(m_ready));
        cmp("tvalid",   32'(toggle_valid),    32'(m_tv));
        cmp("tdata",    32'(toggle_data),     32'(m_td));
        cmp("light",    32'(light_on),        32'(m_light));
        cmp("mismatch", 32'(mismatch),        32'(m_mis));
        cmp("progress", 32'(match_progress),  32'(m_groups));
    endtask

    task automatic tick();
        bit acc;
        acc = suc_claps_valid && m_ready;
        if (toggle_valid && toggle_ready) tok_cnt++;
        if (suc_claps_valid && suc_claps_ready) acc_cnt++;
        @(posedge clock);
        if (reset) begin
            model_clear();
        end else begin
            m_mis   = 0;
            if (m_tv) begin
                if (toggle_ready) begin
                    m_tv = 0; m_groups = 0; m_gaps = 0;
                end
            end else if (acc) begin
                if (suc_claps_data == 0) begin
                    if (m_groups > 0) begin
                        if (m_gaps == GAP_MAX) begin m_groups = 0; m_gaps = 0; end
                        else m_gaps++;
                    end
                end else if (suc_claps_data == GC) begin
                    m_groups++; m_gaps = 0;
                    if (m_groups == SEQ_LEN) begin
                        m_light = !m_light; m_td = m_light; m_tv = 1;
                    end
                end else begin
                    m_mis = 1; m_groups = 0; m_gaps = 0;
                end
            end
            m_ready = !m_tv;
        end
        @(negedge clock);
        check_model();
    endtask

    function automatic vec_t mk(int c, bit v, bit tr, int prog, bit tv, bit light, bit mis);
        vec_t r;
        r.c = W'(c); r.v = v; r.tr = tr; r.prog = 2'(prog); r.tv = tv; r.light = light; r.mis = mis;
        return r;
    endfunction

    initial begin
        bit saw_not_ready;
        int k;
        model_clear();
        reset = 1'b1; suc_claps_data = '0; suc_claps_valid = 1'b0; toggle_ready = 1'b1;
        #1;
        cmp("rst_ready",  32'(suc_claps_ready), 32'd0);
        cmp("rst_tvalid", 32'(toggle_valid),    32'd0);
        cmp("rst_light",  32'(light_on),        32'd0);
        tick();
        reset = 1'b0;
        tick();
        cmp("ready_after_reset", 32'(suc_claps_ready), 32'd1);

        // 2,0,0,2 twice; abort after 5 zeros; 2,3 and 5 mismatches
        vecs.push_back(mk(2,1,1, 1,0,0,0)); vecs.push_back(mk(0,1,1, 1,0,0,0));
        vecs.push_back(mk(0,1,1, 1,0,0,0)); vecs.push_back(mk(2,1,1, 2,1,1,0));
        vecs.push_back(mk(0,0,1, 0,0,1,0)); vecs.push_back(mk(2,1,1, 1,0,1,0));
        vecs.push_back(mk(0,1,1, 1,0,1,0)); vecs.push_back(mk(0,1,1, 1,0,1,0));
        vecs.push_back(mk(2,1,1, 2,1,0,0)); vecs.push_back(mk(0,0,1, 0,0,0,0));
        vecs.push_back(mk(2,1,1, 1,0,0,0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0,1,1, 1,0,0,0));
        vecs.push_back(mk(0,1,1, 0,0,0,0)); vecs.push_back(mk(2,1,1, 1,0,0,0));
        vecs.push_back(mk(2,1,1, 2,1,1,0)); vecs.push_back(mk(0,0,1, 0,0,1,0));
        vecs.push_back(mk(2,1,1, 1,0,1,0)); vecs.push_back(mk(3,1,1, 0,0,1,1));
        vecs.push_back(mk(5,1,1, 0,0,1,1)); vecs.push_back(mk(0,0,1, 0,0,1,0));
        for (int i = 0; i < vecs.size(); i++) begin
            suc_claps_data = vecs[i].c; suc_claps_valid = vecs[i].v; toggle_ready = vecs[i].tr;
            tick();
            cmp($sformatf("vec%0d_prog", i),  32'(match_progress), 32'(vecs[i].prog));
            cmp($sformatf("vec%0d_tv", i),    32'(toggle_valid),   32'(vecs[i].tv));
            cmp($sformatf("vec%0d_light", i), 32'(light_on),       32'(vecs[i].light));
            cmp($sformatf("vec%0d_mis", i),   32'(mismatch),       32'(vecs[i].mis));
        end

        // Back-pressured token with a pending count word
        suc_claps_data = W'(2); suc_claps_valid = 1'b1; toggle_ready = 1'b0;
        tick(); tick();
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cmp("hold_ready",  32'(suc_claps_ready), 32'd0);
            cmp("hold_tvalid", 32'(toggle_valid),    32'd1);
        end
        cmp("hold_no_accept", 32'(acc_cnt), 32'd0);
        toggle_ready = 1'b1;
        tick();
        cmp("exit_ready", 32'(suc_claps_ready), 32'd1);
        cmp("exit_prog",  32'(match_progress),  32'd0);
        tick();
        cmp("pending_accepted", 32'(acc_cnt),        32'd1);
        cmp("pending_prog",     32'(match_progress), 32'd1);
        suc_claps_valid = 1'b0;

        // Asynchronous reset mid-sequence and mid-token
        #2 reset = 1'b1; #1;
        cmp("areset1_prog",  32'(match_progress),  32'd0);
        cmp("areset1_ready", 32'(suc_claps_ready), 32'd0);
        cmp("areset1_light", 32'(light_on),        32'd0);
        model_clear();
        @(negedge clock); reset = 1'b0; tick();
        suc_claps_data = W'(2); suc_claps_valid = 1'b1;
        tick(); tick();
        suc_claps_valid = 1'b0; toggle_ready = 1'b0;
        cmp("pre_areset2_tvalid", 32'(toggle_valid), 32'd1);
        #2 reset = 1'b1; #1;
        cmp("areset2_tvalid", 32'(toggle_valid), 32'd0);
        cmp("areset2_tdata",  32'(toggle_data),  32'd0);
        cmp("areset2_light",  32'(light_on),     32'd0);
        cmp("areset2_prog",   32'(match_progress), 32'd0);
        model_clear();
        @(negedge clock); reset = 1'b0; toggle_ready = 1'b1; tick();

        // Valid held high at full rate with counts 2,2,2,2
        tok_cnt = 0; acc_cnt = 0; saw_not_ready = 0; k = 0;
        suc_claps_data = W'(2); suc_claps_valid = 1'b1;
        while (acc_cnt < 4 && k < 20) begin
            tick();
            if (!suc_claps_ready) saw_not_ready = 1;
            k++;
        end
        suc_claps_valid = 1'b0;
        tick(); tick();
        cmp("rate_accepts",   32'(acc_cnt),       32'd4);
        cmp("rate_tokens",    32'(tok_cnt),       32'd2);
        cmp("rate_not_ready", 32'(saw_not_ready), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0, 1:    suc_claps_data = W'(0);
                2, 3:    suc_claps_data = W'(2);
                default: suc_claps_data = W'($urandom_range(1, 65535));
            endcase
            suc_claps_valid = ($urandom_range(0, 9) < 7);
            toggle_ready    = ($urandom_range(0, 9) < 6);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
